// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants, FSM states and mode helper for the SPI word slave
//
// Contents:
//   DEFAULT_DATA_WIDTH / DEFAULT_RX_DEPTH / DEFAULT_SYNC_STAGES : parameter defaults
//   MODE0..MODE3 : SPI mode encodings as {cpol, cpha}
//   spi_state_t  : word engine FSM states IDLE / LOAD / SHIFT
//   sample_on_rise() : which raw sclk edge carries the mosi sample for a mode
package spi_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_RX_DEPTH    = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_t;

    // Sample edge is the leading edge for cpha=0 and the trailing edge for
    // cpha=1; mapped onto raw sclk polarity this is "rising" for modes 0 and 3.
    function automatic logic sample_on_rise(input logic [1:0] mode);
        logic rise;
        rise = 1'b0;
        case (mode)
            MODE0, MODE3: rise = 1'b1;
            MODE1, MODE2: rise = 1'b0;
            default:      rise = 1'b0;
        endcase
        return rise;
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - synchronous receive FIFO with registered head output
//
// Ports:
//   clock, reset_n       : clock and asynchronous active-low reset
//   push, push_data      : write request and word (ignored while full unless popping)
//   pop                  : remove head word (ignored while empty)
//   head_data            : registered head word, valid while empty == 0
//   empty                : registered, a pushed word shows up on the next clock
//   full                 : count == DEPTH
module spi_rx_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         head_idx;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  push_ok;
    logic                  pop_ok;

    assign full       = (count == CW'(DEPTH));
    assign pop_ok     = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
    assign push_ok    = push & (~full | pop_ok);
    assign count_next = count + CW'(push_ok) - CW'(pop_ok);
    assign head_idx   = pop_ok ? rd_ptr + AW'(1) : rd_ptr;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
            empty     <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= head_idx;
            end
            count <= count_next;
            empty <= (count_next == '0);
            // The word being written this cycle bypasses memory when it lands
            // in the slot that becomes the new head.
            if (count_next != '0) begin
                head_data <= (push_ok && (wr_ptr == head_idx)) ? push_data : mem[head_idx];
            end
        end
    end

endmodule

// File: rtl/spi_word_slave.sv
// rtl/spi_word_slave.sv - SPI slave word engine with runtime mode, RX FIFO and TX handshake
//
// Optional feature macro: SPI_FRAME_ERR_EN (adds frame_err and err_count).
//
// Ports:
//   clock, reset_n        : system clock, asynchronous active-low reset
//   sclk, ss_n, mosi      : SPI pins, asynchronous, synchronised internally
//   miso, miso_oe         : SPI data out and pad enable (enable only while selected)
//   cpol, cpha            : SPI mode, captured when ss_n falls
//   tx_data, tx_valid     : word to transmit; tx_ready pulses when it is accepted
//   rx_data, rx_valid     : head of the receive FIFO; rx_ready pops it
//   rx_overflow           : sticky, a completed word was dropped on a full FIFO
//   busy                  : a frame is in progress
//   frame_err, err_count  : (SPI_FRAME_ERR_EN) partial-word abort pulse and saturating count
module spi_word_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int RX_DEPTH    = DEFAULT_RX_DEPTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overflow,
    output logic                  busy
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic                  frame_err,
    output logic [7:0]            err_count
`endif
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // Synchronisers. The ss_n chain clears to 0 (as if selected) so that a
    // reset released while ss_n is low produces no falling edge: a new frame
    // starts only after ss_n has been observed high again.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   ss_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            ss_prev   <= ss_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic ss_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic ss_rise;
    logic ss_fall;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_prev & sclk_s;
    assign sclk_fall = sclk_prev & ~sclk_s;
    assign ss_rise   = ~ss_prev & ss_s;
    assign ss_fall   = ss_prev & ~ss_s;

    // Mode and datapath state
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic [DATA_WIDTH-1:0] echo_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  skip_shift;
    logic                  accept_pending;

    logic                  sample_edge;
    logic                  shift_edge;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [DATA_WIDTH-1:0] echo_next;

    assign sample_edge = sample_on_rise(mode_q) ? sclk_rise : sclk_fall;
    assign shift_edge  = sample_on_rise(mode_q) ? sclk_fall : sclk_rise;
    assign rx_word     = {rx_shift, mosi_s};

    // FSM
    spi_state_t state;
    spi_state_t state_next;
    logic       load_tx;
    logic       sample_en;
    logic       shift_en;
    logic       word_done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_tx    = 1'b0;
        sample_en  = 1'b0;
        shift_en   = 1'b0;
        word_done  = 1'b0;
        tx_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load_tx    = 1'b1;
                tx_ready   = tx_valid;
                state_next = SHIFT;
            end
            SHIFT: begin
                sample_en = sample_edge;
                shift_en  = shift_edge;
                word_done = sample_edge && (bit_cnt == LAST_BIT);
                load_tx   = word_done;
                // A word loaded at the end of the previous word is only
                // acknowledged once the next word actually starts, so a frame
                // that ends cleanly leaves tx_data with the producer.
                tx_ready  = sample_edge & accept_pending;
            end
            default: state_next = IDLE;
        endcase
        if (ss_rise) begin
            state_next = IDLE;
            load_tx    = 1'b0;
            sample_en  = 1'b0;
            shift_en   = 1'b0;
            word_done  = 1'b0;
            tx_ready   = 1'b0;
        end
    end

    assign echo_next = word_done ? rx_word : echo_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q         <= MODE0;
            tx_shift       <= '0;
            rx_shift       <= '0;
            echo_q         <= '0;
            bit_cnt        <= '0;
            skip_shift     <= 1'b0;
            accept_pending <= 1'b0;
        end else begin
            if (ss_fall) begin
                mode_q <= {cpol, cpha};
            end
            if (sample_en) begin
                rx_shift       <= rx_word[DATA_WIDTH-2:0];
                bit_cnt        <= word_done ? '0 : bit_cnt + CNT_W'(1);
                accept_pending <= 1'b0;
            end
            if (word_done) begin
                echo_q <= rx_word;
            end
            if (load_tx) begin
                tx_shift       <= tx_valid ? tx_data : echo_next;
                // The MSB is already on miso, so the next shift edge must not
                // advance it: at frame start that is only the cpha=1 leading
                // edge, after an in-frame reload it is always the next one.
                skip_shift     <= (state == LOAD) ? mode_q[0] : 1'b1;
                accept_pending <= (state == SHIFT) & tx_valid;
            end else if (shift_en) begin
                if (skip_shift) begin
                    skip_shift <= 1'b0;
                end else begin
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end
            if (state != SHIFT) begin
                bit_cnt        <= '0;
                accept_pending <= 1'b0;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign miso_oe = busy;
    assign miso    = miso_oe & tx_shift[DATA_WIDTH-1];

    // Receive FIFO
    logic fifo_empty;
    logic fifo_full;
    logic fifo_pop;

    assign rx_valid = ~fifo_empty;
    assign fifo_pop = rx_valid & rx_ready;

    spi_rx_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (RX_DEPTH)
    ) u_rx_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (word_done),
        .push_data(rx_word),
        .pop      (fifo_pop),
        .head_data(rx_data),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_overflow <= 1'b0;
        end else if (word_done && fifo_full && !fifo_pop) begin
            rx_overflow <= 1'b1;
        end
    end

`ifdef SPI_FRAME_ERR_EN
    logic partial_abort;

    assign partial_abort = ss_rise && (state == SHIFT) && (bit_cnt != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
            err_count <= 8'd0;
        end else begin
            frame_err <= partial_abort;
            if (partial_abort && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_word_slave.sv
// tb/tb_spi_word_slave.sv - directed self-checking bench for spi_word_slave
module tb_spi_word_slave;
    import spi_pkg::*;

    localparam int H = 80;

    logic        clock;
    logic        reset_n;
    logic        sclk;
    logic        ss_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic        cpol;
    logic        cpha;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_overflow;
    logic        busy;
`ifdef SPI_FRAME_ERR_EN
    logic        frame_err;
    logic [7:0]  err_count;
`endif

    spi_word_slave #(
        .DATA_WIDTH (32),
        .RX_DEPTH   (4),
        .SYNC_STAGES(2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sclk       (sclk),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .cpol       (cpol),
        .cpha       (cpha),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_overflow(rx_overflow),
        .busy       (busy)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err  (frame_err),
        .err_count  (err_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int txr_cnt = 0;
    int ferr_cnt = 0;
    int snap;

    logic [31:0] mo_w [0:7];
    logic [31:0] mi_w [0:7];

    always @(negedge clock) begin
        if (tx_ready === 1'b1) txr_cnt++;
`ifdef SPI_FRAME_ERR_EN
        if (frame_err === 1'b1) ferr_cnt++;
`endif
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Master: clocks nbits bits of mo_w[] MSB first, captures miso into mi_w[].
    task automatic spi_frame(input logic pol, input logic pha, input int nbits, input logic end_frame);
        ss_n = 1'b1;
        cpol = pol;
        cpha = pha;
        sclk = pol;
        #(2*H);
        ss_n = 1'b0;
        #(2*H);
        for (int i = 0; i < nbits; i++) begin
            int w;
            int b;
            w = i / 32;
            b = 31 - (i % 32);
            if (!pha) begin
                mosi = mo_w[w][b];
                #(H);
                sclk = ~pol;
                mi_w[w][b] = miso;
                #(H);
                sclk = pol;
            end else begin
                sclk = ~pol;
                mosi = mo_w[w][b];
                #(H);
                sclk = pol;
                mi_w[w][b] = miso;
                #(H);
            end
        end
        #(2*H);
        if (end_frame) begin
            ss_n = 1'b1;
            #(2*H);
        end
    endtask

    task automatic pop_exp(input string tag, input logic [31:0] exp);
        @(negedge clock);
        chk({tag, " valid"}, 64'(rx_valid), 64'd1);
        chk({tag, " data"}, 64'(rx_data), 64'(exp));
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        sclk     = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        tx_data  = 32'h0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);

        chk("rst miso", 64'(miso), 64'd0);
        chk("rst miso_oe", 64'(miso_oe), 64'd0);
        chk("rst tx_ready", 64'(tx_ready), 64'd0);
        chk("rst rx_valid", 64'(rx_valid), 64'd0);
        chk("rst rx_data", 64'(rx_data), 64'd0);
        chk("rst rx_overflow", 64'(rx_overflow), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
`ifdef SPI_FRAME_ERR_EN
        chk("rst frame_err", 64'(frame_err), 64'd0);
        chk("rst err_count", 64'(err_count), 64'd0);
`endif

        // Mode 0 echo path
        snap = txr_cnt;
        mo_w[0] = 32'hBEEFFACE;
        spi_frame(1'b0, 1'b0, 32, 1'b1);
        chk("m0 f1 miso", 64'(mi_w[0]), 64'h0);
        pop_exp("m0 f1 rx", 32'hBEEFFACE);
        mo_w[0] = 32'h0000_0000;
        spi_frame(1'b0, 1'b0, 32, 1'b1);
        chk("m0 f2 echo", 64'(mi_w[0]), 64'hBEEFFACE);
        pop_exp("m0 f2 rx", 32'h0000_0000);
        chk("m0 no tx_ready", 64'(txr_cnt - snap), 64'd0);
        chk("m0 busy after", 64'(busy), 64'd0);

        // Modes 1..3 with TX handshake
        tx_data  = 32'h1234_5678;
        tx_valid = 1'b1;
        mo_w[0]  = 32'hA5C3_0F96;
        for (int m = 1; m < 4; m++) begin
            logic [1:0] md;
            md = 2'(m);
            snap = txr_cnt;
            spi_frame(md[1], md[0], 32, 1'b1);
            chk($sformatf("mode%0d miso", m), 64'(mi_w[0]), 64'h1234_5678);
            chk($sformatf("mode%0d tx_ready", m), 64'(txr_cnt - snap), 64'd1);
            pop_exp($sformatf("mode%0d rx", m), 32'hA5C3_0F96);
        end
        tx_valid = 1'b0;

        // Back-to-back words in one frame
        mo_w[0] = 32'h1;
        mo_w[1] = 32'h2;
        mo_w[2] = 32'h3;
        spi_frame(1'b0, 1'b0, 96, 1'b1);
        chk("b2b first miso", 64'(mi_w[0]), 64'hA5C3_0F96);
        chk("b2b overflow", 64'(rx_overflow), 64'd0);
        pop_exp("b2b w0", 32'h1);
        pop_exp("b2b w1", 32'h2);
        pop_exp("b2b w2", 32'h3);
        chk("b2b drained", 64'(rx_valid), 64'd0);

        // Overflow: five words into a four-deep FIFO
        for (int k = 0; k < 5; k++) mo_w[k] = 32'(k + 1);
        spi_frame(1'b0, 1'b0, 160, 1'b1);
        chk("ovf flag", 64'(rx_overflow), 64'd1);
        pop_exp("ovf w0", 32'h1);
        pop_exp("ovf w1", 32'h2);
        pop_exp("ovf w2", 32'h3);
        pop_exp("ovf w3", 32'h4);
        chk("ovf drained", 64'(rx_valid), 64'd0);
        chk("ovf sticky", 64'(rx_overflow), 64'd1);

        // Abort after 13 bits: no push, echo unchanged
        mo_w[0] = 32'h1357_2468;
        spi_frame(1'b0, 1'b0, 32, 1'b1);
        pop_exp("pre-abort rx", 32'h1357_2468);
        snap = ferr_cnt;
        mo_w[0] = 32'hFFFF_FFFF;
        spi_frame(1'b0, 1'b0, 13, 1'b1);
        chk("abort no push", 64'(rx_valid), 64'd0);
`ifdef SPI_FRAME_ERR_EN
        chk("abort frame_err pulses", 64'(ferr_cnt - snap), 64'd1);
        chk("abort err_count", 64'(err_count), 64'd1);
`endif
        mo_w[0] = 32'hCAFE_F00D;
        spi_frame(1'b0, 1'b0, 32, 1'b1);
        chk("abort echo kept", 64'(mi_w[0]), 64'h1357_2468);
        pop_exp("post-abort rx", 32'hCAFE_F00D);

        // Reset mid-frame at bit 20 (rx_data still holds the last popped head)
        mo_w[0] = 32'hFFFF_FFFF;
        spi_frame(1'b0, 1'b0, 20, 1'b0);
        @(negedge clock);
        chk("mid busy before rst", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #(35);
        chk("mid rst busy", 64'(busy), 64'd0);
        chk("mid rst miso_oe", 64'(miso_oe), 64'd0);
        chk("mid rst miso", 64'(miso), 64'd0);
        chk("mid rst overflow", 64'(rx_overflow), 64'd0);
        chk("mid rst rx_valid", 64'(rx_valid), 64'd0);
        chk("mid rst rx_data", 64'(rx_data), 64'd0);
        chk("mid rst tx_ready", 64'(tx_ready), 64'd0);
`ifdef SPI_FRAME_ERR_EN
        chk("mid rst err_count", 64'(err_count), 64'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        chk("mid no resume while low", 64'(busy), 64'd0);
        mo_w[0] = 32'h89AB_CDEF;
        spi_frame(1'b0, 1'b0, 32, 1'b1);
        chk("mid next echo cleared", 64'(mi_w[0]), 64'h0);
        pop_exp("mid next rx", 32'h89AB_CDEF);
        chk("mid next overflow", 64'(rx_overflow), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_word_slave.md
Name: spi_word_slave

Overview:
- Parametrised SPI slave word engine; successor to the fixed 32-bit, mode-0 passthrough path in the actuator controller.
- Sits between the mprj_io SPI pins (sclk, mosi, ss_n, miso) and the actuator register/latch logic.
- Adds configurable word width, runtime CPOL/CPHA, a receive FIFO and a transmit handshake.
- When no TX word is supplied, the block falls back to echoing the last received word.

Parameters:
- DATA_WIDTH, 32, bits per SPI word (8..64).
- RX_DEPTH, 4, receive FIFO depth in words (power of two, >=2).
- SYNC_STAGES, 2, synchroniser flops on sclk, mosi and ss_n (>=2).

Ports:
- clock  input  1  system clock; all logic is in this domain.
- reset_n  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI clock, asynchronous to clock.
- ss_n  input  1  SPI slave select, active-low, asynchronous.
- mosi  input  1  SPI data in, asynchronous.
- miso  output  1  SPI data out.
- miso_oe  output  1  miso pad output enable; 1 only while the slave is selected.
- cpol  input  1  clock polarity; sampled while ss_n is high.
- cpha  input  1  clock phase; sampled while ss_n is high.
- tx_data  input  DATA_WIDTH  word to shift out in the next frame.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  pulses for one cycle when tx_data is accepted.
- rx_data  output  DATA_WIDTH  head of the RX FIFO.
- rx_valid  output  1  RX FIFO is not empty.
- rx_ready  input  1  consumer pops the RX FIFO head.
- rx_overflow  output  1  sticky flag: a completed word was dropped because the FIFO was full.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=0, rx_valid=0, rx_data=0, rx_overflow=0, busy=0. The echo register, shift registers and bit counter also clear to 0.
- Synchronisation: sclk, ss_n and mosi each pass through SYNC_STAGES flops. Edges are detected on the synchronised sclk. The supported ratio is f_sclk <= f_clock/4.
- Mode latch: {cpol, cpha} are captured on the synchronised falling edge of ss_n and held constant until ss_n rises.
- Edge definitions: leading edge = first sclk transition away from idle level cpol; trailing edge = the opposite transition.
  - cpha=0: sample on the leading edge, shift on the trailing edge.
  - cpha=1: shift on the leading edge, sample on the trailing edge.
- Bit order: MSB first on both mosi and miso.
- FSM states:
  - IDLE: ss_n high; miso_oe=0; busy=0.
  - LOAD: one cycle after the ss_n falling edge. If tx_valid=1, the TX shifter loads tx_data and tx_ready pulses for that cycle. If tx_valid=0, the shifter loads the echo register and tx_ready stays 0. In both cases miso takes the MSB and miso_oe=1. Transition to SHIFT.
  - SHIFT: each sample edge shifts the synchronised mosi into the RX shifter and increments the bit counter. Each shift edge (except the first when cpha=1) advances miso. When the bit counter reaches DATA_WIDTH:
    - the RX word is pushed to the FIFO and copied into the echo register;
    - the counter wraps to 0 and the TX shifter reloads exactly as in LOAD;
    - this supports back-to-back words within a single ss_n low period.
  - ss_n rising edge from any state returns to IDLE. A partial word (counter != 0) is discarded: no push, echo unchanged.
- RX FIFO:
  - push when not full;
  - if a push occurs while full, drop the word and set rx_overflow, which stays set until reset;
  - simultaneous push and pop when full succeeds, with no overflow;
  - pop when rx_valid && rx_ready;
  - rx_data/rx_valid are registered, and a pushed word becomes visible on the next clock.
- Reset mid-frame: all state clears immediately. The frame is resumed only after ss_n has been seen high again.

Optional Feature:
- Macro SPI_FRAME_ERR_EN.
- When defined:
  - adds output frame_err (1 bit, reset 0);
  - frame_err pulses for one cycle when ss_n rises with a bit count between 1 and DATA_WIDTH-1;
  - adds output err_count (8 bits, saturating at 255, reset 0), which counts those events.
- When not defined: neither port exists, and partial frames are dropped silently.

Decomposition:
- Shared package spi_pkg holds:
  - SPI mode encoding constants (MODE0..MODE3 = {cpol, cpha});
  - FSM state localparams IDLE/LOAD/SHIFT;
  - default width and depth constants.
- One sub-module, spi_rx_fifo: a synchronous FIFO parametrised by DATA_WIDTH and RX_DEPTH, providing full, empty and registered output.

Test Plan:
- Mode 0, DATA_WIDTH=32, tx_valid=0: send 0xBEEFFACE, then 0x00000000 -> rx pops 0xBEEFFACE then 0x00000000; miso during the second frame = 0xBEEFFACE (echo).
- Modes 1, 2 and 3: send 0xA5C3_0F96 with tx_data=0x1234_5678, tx_valid=1 -> rx = 0xA5C30F96; master receives 0x12345678; tx_ready pulses exactly once per frame.
- Back-to-back: three words 0x1, 0x2, 0x3 under one ss_n low, rx_ready=0, RX_DEPTH=4 -> three words queued in order; rx_overflow=0.
- Overflow: five words with rx_ready=0 -> the FIFO holds the first four; rx_overflow=1; popping yields 0x1..0x4.
- Abort: ss_n rises after 13 bits -> no push and echo unchanged; with SPI_FRAME_ERR_EN, frame_err pulses once and err_count=1.
- Reset_n pulsed low mid-frame at bit 20 -> all outputs return to reset values; the next full frame after ss_n toggles is received correctly.
